// File: rtl/forwarding_scoreboard.sv
// Register pending-bit scoreboard with operand bypass for multi-port reads.
// Long-latency issues mark a destination pending; completions or bypasses release the operand.
module forwarding_scoreboard #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_FWD = 4,
  parameter int unsigned NUM_RD  = 4,
  parameter int unsigned NUM_ISS = 2,
  parameter int unsigned NUM_CMP = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_ISS-1:0]          iss_en,
  input  logic [NUM_ISS*ADDR_W-1:0]   iss_addr,
  input  logic [NUM_CMP-1:0]          cmp_en,
  input  logic [NUM_CMP*ADDR_W-1:0]   cmp_addr,
  input  logic [NUM_CMP*DATA_W-1:0]   cmp_data,
  input  logic [NUM_FWD-1:0]          fwd_en,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
  input  logic [NUM_RD-1:0]           rd_req,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
  input  logic [NUM_RD*DATA_W-1:0]    rd_rf_data,
  output logic [NUM_RD*DATA_W-1:0]    rd_data,
  output logic [NUM_RD-1:0]           rd_ready,
  output logic                        stall,
  output logic [ADDR_W:0]             pending_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [DEPTH-1:0] iss_mask;
  logic [DEPTH-1:0] cmp_mask;
  logic [ADDR_W:0]  cnt_nxt;

  always_comb begin
    iss_mask = '0;
    cmp_mask = '0;
    for (int unsigned i = 0; i < NUM_ISS; i++)
      if (iss_en[i]) iss_mask[iss_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    for (int unsigned j = 0; j < NUM_CMP; j++)
      if (cmp_en[j]) cmp_mask[cmp_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    // Issue is applied after the completion clear so it wins on a collision.
    pending_nxt    = (pending & ~cmp_mask) | iss_mask;
    pending_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int unsigned r = 0; r < DEPTH; r++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pending_nxt[r]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else if (flush) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  always_comb begin : read_mux
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] sel;
    logic              hit;
    a        = '0;
    sel      = '0;
    hit      = 1'b0;
    rd_data  = '0;
    rd_ready = '1;
    stall    = 1'b0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      a   = rd_addr[p*ADDR_W +: ADDR_W];
      sel = rd_rf_data[p*DATA_W +: DATA_W];
      hit = 1'b0;
      // Scan high-to-low so the lowest-index match is written last; bypass overrides completion.
      for (int unsigned j = NUM_CMP; j > 0; j--)
        if (cmp_en[j-1] && (cmp_addr[(j-1)*ADDR_W +: ADDR_W] == a)) begin
          sel = cmp_data[(j-1)*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      for (int unsigned i = NUM_FWD; i > 0; i--)
        if (fwd_en[i-1] && (fwd_addr[(i-1)*ADDR_W +: ADDR_W] == a)) begin
          sel = fwd_data[(i-1)*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      if (a == '0) sel = '0;
      rd_data[p*DATA_W +: DATA_W] = sel;
      rd_ready[p] = ~pending[a] | hit;
      stall       = stall | (rd_req[p] & ~rd_ready[p]);
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed checks on the default configuration, then random traffic on NUM_FWD=1/6, NUM_RD=2
// instances compared against a behavioural pending-set model.
module tb_forwarding_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default-configuration DUT
  logic         rst, flush;
  logic [1:0]   iss_en;
  logic [9:0]   iss_addr;
  logic [1:0]   cmp_en;
  logic [9:0]   cmp_addr;
  logic [63:0]  cmp_data;
  logic [3:0]   fwd_en;
  logic [19:0]  fwd_addr;
  logic [127:0] fwd_data;
  logic [3:0]   rd_req;
  logic [19:0]  rd_addr;
  logic [127:0] rd_rf_data;
  logic [127:0] rd_data;
  logic [3:0]   rd_ready;
  logic         stall;
  logic [5:0]   pending_cnt;

  forwarding_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .cmp_en(cmp_en), .cmp_addr(cmp_addr), .cmp_data(cmp_data),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rf_data(rd_rf_data),
    .rd_data(rd_data), .rd_ready(rd_ready), .stall(stall), .pending_cnt(pending_cnt)
  );

  // sweep DUTs: ADDR_W=3, DATA_W=16, NUM_RD=2
  logic         s_rst, s_flush;
  logic [1:0]   s_iss_en;
  logic [5:0]   s_iss_addr;
  logic [1:0]   s_cmp_en;
  logic [5:0]   s_cmp_addr;
  logic [31:0]  s_cmp_data;
  logic [5:0]   s_fwd_en;
  logic [17:0]  s_fwd_addr;
  logic [95:0]  s_fwd_data;
  logic [1:0]   s_rd_req;
  logic [5:0]   s_rd_addr;
  logic [31:0]  s_rd_rf;
  logic [31:0]  a_rd_data, b_rd_data;
  logic [1:0]   a_rd_ready, b_rd_ready;
  logic         a_stall, b_stall;
  logic [3:0]   a_cnt, b_cnt;

  forwarding_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_FWD(1), .NUM_RD(2), .NUM_ISS(2), .NUM_CMP(2)) u_f1 (
    .clk(clk), .rst(s_rst), .flush(s_flush),
    .iss_en(s_iss_en), .iss_addr(s_iss_addr),
    .cmp_en(s_cmp_en), .cmp_addr(s_cmp_addr), .cmp_data(s_cmp_data),
    .fwd_en(s_fwd_en[0:0]), .fwd_addr(s_fwd_addr[2:0]), .fwd_data(s_fwd_data[15:0]),
    .rd_req(s_rd_req), .rd_addr(s_rd_addr), .rd_rf_data(s_rd_rf),
    .rd_data(a_rd_data), .rd_ready(a_rd_ready), .stall(a_stall), .pending_cnt(a_cnt)
  );

  forwarding_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_FWD(6), .NUM_RD(2), .NUM_ISS(2), .NUM_CMP(2)) u_f6 (
    .clk(clk), .rst(s_rst), .flush(s_flush),
    .iss_en(s_iss_en), .iss_addr(s_iss_addr),
    .cmp_en(s_cmp_en), .cmp_addr(s_cmp_addr), .cmp_data(s_cmp_data),
    .fwd_en(s_fwd_en), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data),
    .rd_req(s_rd_req), .rd_addr(s_rd_addr), .rd_rf_data(s_rd_rf),
    .rd_data(b_rd_data), .rd_ready(b_rd_ready), .stall(b_stall), .pending_cnt(b_cnt)
  );

  bit [7:0] mpend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_en = '0; iss_addr = '0; cmp_en = '0; cmp_addr = '0; cmp_data = '0;
    fwd_en = '0; fwd_addr = '0; fwd_data = '0;
    rd_req = '0; rd_addr = '0; rd_rf_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic iss(input int p, input logic [4:0] a);
    iss_en[p] = 1'b1; iss_addr[p*5 +: 5] = a;
  endtask

  task automatic cmp(input int p, input logic [4:0] a, input logic [31:0] d);
    cmp_en[p] = 1'b1; cmp_addr[p*5 +: 5] = a; cmp_data[p*32 +: 32] = d;
  endtask

  task automatic fwd(input int p, input logic [4:0] a, input logic [31:0] d);
    fwd_en[p] = 1'b1; fwd_addr[p*5 +: 5] = a; fwd_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [31:0] rf);
    rd_req[p] = 1'b1; rd_addr[p*5 +: 5] = a; rd_rf_data[p*32 +: 32] = rf;
  endtask

  // Reference operand resolution: first matching bypass, else first matching completion, else RF.
  task automatic exp_read(input int nf, input int p, output logic [15:0] d, output logic rdy);
    logic [2:0] a;
    int fi, ci;
    a  = s_rd_addr[p*3 +: 3];
    fi = -1;
    ci = -1;
    for (int i = 0; i < nf; i++)
      if (fi < 0 && s_fwd_en[i] && s_fwd_addr[i*3 +: 3] == a) fi = i;
    for (int j = 0; j < 2; j++)
      if (ci < 0 && s_cmp_en[j] && s_cmp_addr[j*3 +: 3] == a) ci = j;
    if (a == 3'd0)   d = 16'h0;
    else if (fi >= 0) d = s_fwd_data[fi*16 +: 16];
    else if (ci >= 0) d = s_cmp_data[ci*16 +: 16];
    else              d = s_rd_rf[p*16 +: 16];
    rdy = !mpend[a] || fi >= 0 || ci >= 0;
  endtask

  initial begin
    logic [15:0] ed;
    logic        er, es;
    idle();
    rst = 1'b0; flush = 1'b0;
    s_rst = 1'b0; s_flush = 1'b0; s_iss_en = '0; s_iss_addr = '0; s_cmp_en = '0; s_cmp_addr = '0;
    s_cmp_data = '0; s_fwd_en = '0; s_fwd_addr = '0; s_fwd_data = '0; s_rd_req = '0; s_rd_addr = '0;
    s_rd_rf = '0;
    mpend = '0;

    // reset behaviour: reads pass RF data, issue ignored
    @(negedge clk);
    rd(0, 5'd3, 32'hAAAA5555); rd(1, 5'd0, 32'hBBBB0000); iss(0, 5'd6);
    #1;
    chk("rst_data0", rd_data[31:0], 32'hAAAA5555);
    chk("rst_data1", rd_data[63:32], 32'h0);
    chk("rst_ready", {28'h0, rd_ready}, 32'hF);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    step();
    chk("rst_cnt", {26'h0, pending_cnt}, 32'h0);
    rst = 1'b1; idle();

    // pend r5, stall, then completion releases it in the same cycle
    iss(0, 5'd5);
    step(); idle();
    rd(0, 5'd5, 32'h00001234);
    #1;
    chk("r5_ready", {31'h0, rd_ready[0]}, 32'h0);
    chk("r5_stall", {31'h0, stall}, 32'h1);
    chk("r5_cnt", {26'h0, pending_cnt}, 32'h1);
    cmp(0, 5'd5, 32'hDEADBEEF);
    #1;
    chk("r5_cmp_data", rd_data[31:0], 32'hDEADBEEF);
    chk("r5_cmp_ready", {31'h0, rd_ready[0]}, 32'h1);
    chk("r5_cmp_stall", {31'h0, stall}, 32'h0);
    step(); idle();
    chk("r5_cnt_clr", {26'h0, pending_cnt}, 32'h0);

    // priority among sources
    rd(1, 5'd7, 32'h00000077);
    fwd(2, 5'd7, 32'h22); fwd(1, 5'd7, 32'h11); cmp(0, 5'd7, 32'h33);
    #1 chk("prio_fwd1", rd_data[63:32], 32'h11);
    fwd_en = '0;
    #1 chk("prio_cmp0", rd_data[63:32], 32'h33);
    cmp_en = '0;
    #1 chk("prio_rf", rd_data[63:32], 32'h77);
    fwd(3, 5'd7, 32'h44); fwd(0, 5'd7, 32'h01); cmp(1, 5'd7, 32'h55);
    #1 chk("prio_fwd0", rd_data[63:32], 32'h01);
    step(); idle();

    // duplicate issue and completion to a non-pending register
    iss(0, 5'd20); iss(1, 5'd20);
    step(); idle();
    chk("dup_iss_cnt", {26'h0, pending_cnt}, 32'h1);
    iss(0, 5'd20);
    step(); idle();
    chk("reiss_cnt", {26'h0, pending_cnt}, 32'h1);
    cmp(1, 5'd21, 32'h2121); rd(2, 5'd21, 32'h0);
    #1 chk("np_cmp_data", rd_data[95:64], 32'h2121);
    step(); idle();
    chk("np_cmp_cnt", {26'h0, pending_cnt}, 32'h1);
    cmp(0, 5'd20, 32'h0);
    step(); idle();
    chk("r20_clr_cnt", {26'h0, pending_cnt}, 32'h0);

    // issue beats completion on the same register
    iss(0, 5'd9);
    step(); idle();
    chk("r9_cnt", {26'h0, pending_cnt}, 32'h1);
    iss(1, 5'd9); cmp(0, 5'd9, 32'h99);
    step(); idle();
    chk("r9_collide_cnt", {26'h0, pending_cnt}, 32'h1);
    rd(0, 5'd9, 32'h0);
    #1 chk("r9_still_pend", {31'h0, rd_ready[0]}, 32'h0);
    cmp(1, 5'd9, 32'h0);
    step(); idle();
    chk("r9_clr_cnt", {26'h0, pending_cnt}, 32'h0);

    // flush overrides issue
    iss(0, 5'd1); iss(1, 5'd2);
    step(); idle();
    iss(0, 5'd3);
    step(); idle();
    chk("pend3_cnt", {26'h0, pending_cnt}, 32'h3);
    flush = 1'b1; iss(0, 5'd4); rd(0, 5'd1, 32'h1);
    #1 chk("flush_cyc_ready", {31'h0, rd_ready[0]}, 32'h0);
    step(); idle(); flush = 1'b0;
    rd(0, 5'd1, 32'h1); rd(1, 5'd2, 32'h2); rd(2, 5'd3, 32'h3); rd(3, 5'd4, 32'h4);
    #1;
    chk("flush_cnt", {26'h0, pending_cnt}, 32'h0);
    chk("flush_ready", {28'h0, rd_ready}, 32'hF);
    chk("flush_stall", {31'h0, stall}, 32'h0);
    idle();

    // reset mid-operation, then writes to r0 never pend
    iss(0, 5'd10); iss(1, 5'd11);
    step(); idle();
    iss(0, 5'd12); iss(1, 5'd13);
    step(); idle();
    iss(0, 5'd14);
    step(); idle();
    chk("pend5_cnt", {26'h0, pending_cnt}, 32'h5);
    rd(0, 5'd10, 32'h0);
    #1 chk("pend5_stall", {31'h0, stall}, 32'h1);
    rst = 1'b0; flush = 1'b1; iss(1, 5'd15);
    step(); idle(); rst = 1'b1; flush = 1'b0;
    rd(0, 5'd10, 32'h0);
    #1;
    chk("mid_rst_cnt", {26'h0, pending_cnt}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    idle();
    iss(0, 5'd0); iss(1, 5'd0);
    step(); idle();
    rd(0, 5'd0, 32'hFFFFFFFF); fwd(0, 5'd0, 32'h55); cmp(0, 5'd0, 32'h66);
    #1;
    chk("r0_data", rd_data[31:0], 32'h0);
    chk("r0_ready", {31'h0, rd_ready[0]}, 32'h1);
    chk("r0_cnt", {26'h0, pending_cnt}, 32'h0);
    idle();

    // pend every register for the maximum count
    for (int r = 1; r < 32; r += 2) begin
      iss(0, 5'(r));
      if (r + 1 < 32) iss(1, 5'(r + 1));
      step(); idle();
    end
    chk("full_cnt", {26'h0, pending_cnt}, 32'd31);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("full_flush_cnt", {26'h0, pending_cnt}, 32'h0);

    // random sweep on NUM_FWD=1 and NUM_FWD=6
    for (int c = 0; c < 400; c++) begin
      s_rst      = ($urandom_range(0, 39) != 0);
      s_flush    = ($urandom_range(0, 24) == 0);
      s_iss_en   = 2'($urandom_range(0, 3));
      s_iss_addr = 6'($urandom);
      s_cmp_en   = 2'($urandom_range(0, 3));
      s_cmp_addr = 6'($urandom);
      s_cmp_data = $urandom;
      for (int i = 0; i < 6; i++) s_fwd_en[i] = ($urandom_range(0, 2) == 0);
      s_fwd_addr = 18'($urandom);
      s_fwd_data = {$urandom, $urandom, $urandom};
      s_rd_req   = 2'($urandom_range(0, 3));
      s_rd_addr  = 6'($urandom);
      s_rd_rf    = $urandom;
      #1;
      es = 1'b0;
      for (int p = 0; p < 2; p++) begin
        exp_read(1, p, ed, er);
        chk("f1_data", {16'h0, a_rd_data[p*16 +: 16]}, {16'h0, ed});
        chk("f1_ready", {31'h0, a_rd_ready[p]}, {31'h0, er});
        if (s_rd_req[p] && !er) es = 1'b1;
      end
      chk("f1_stall", {31'h0, a_stall}, {31'h0, es});
      es = 1'b0;
      for (int p = 0; p < 2; p++) begin
        exp_read(6, p, ed, er);
        chk("f6_data", {16'h0, b_rd_data[p*16 +: 16]}, {16'h0, ed});
        chk("f6_ready", {31'h0, b_rd_ready[p]}, {31'h0, er});
        if (s_rd_req[p] && !er) es = 1'b1;
      end
      chk("f6_stall", {31'h0, b_stall}, {31'h0, es});
      @(posedge clk);
      if (!s_rst || s_flush) mpend = '0;
      else begin
        for (int j = 0; j < 2; j++)
          if (s_cmp_en[j]) mpend[s_cmp_addr[j*3 +: 3]] = 1'b0;
        for (int i = 0; i < 2; i++)
          if (s_iss_en[i] && s_iss_addr[i*3 +: 3] != 3'd0) mpend[s_iss_addr[i*3 +: 3]] = 1'b1;
      end
      @(negedge clk);
      chk("f1_cnt", {28'h0, a_cnt}, $countones(mpend));
      chk("f6_cnt", {28'h0, b_cnt}, $countones(mpend));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
